tw_gen: RTL and testbench

Parametrised, streaming twiddle-factor generator for the radix-2 DIF FFT datapath. On a start pulse it emits, in butterfly order, the N/2 twiddles W_N^m for a selected stage, with a valid/ready handshake and an optional conjugate (IFFT) mode. A quarter-wave cosine ROM plus symmetry logic replaces per-stage half-wave tables. It feeds the stage butterfly multipliers in place of the fixed per-stage twiddle memories.

---
 rtl/tw_gen.sv | 119 +++++++++++
 tb/tb_tw_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tw_gen.sv
// tw_gen: streaming radix-2 DIF twiddle generator built on a quarter-wave cosine ROM.
// Emits the N/2 twiddles W_N^m of one stage in butterfly order, optionally conjugated.
module tw_gen #(
    parameter  int LOG2N = 4,
    parameter  int TW_W  = 12,
    localparam int SW    = $clog2(LOG2N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SW-1:0]          stage,
    input  logic                   inv,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [LOG2N-2:0]       out_idx,
    output logic signed [TW_W-1:0] twiddle_re,
    output logic signed [TW_W-1:0] twiddle_im
);
    localparam int MW = LOG2N - 1;
    localparam int N = 1 << LOG2N;
    localparam int Q = N / 4;
    localparam logic [MW-1:0] QM = MW'(Q);
    localparam real PI = 3.14159265358979323846;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;

    function automatic logic [(Q+1)*TW_W-1:0] rom_init();
        logic [(Q+1)*TW_W-1:0] r;
        real a;
        r = '0;
        a = real'((1 << (TW_W - 1)) - 1);
        for (int k = 0; k <= Q; k++)
            r[k*TW_W +: TW_W] = TW_W'($rtoi(a * $cos(2.0 * PI * real'(k) / real'(N)) + 0.5));
        return r;
    endfunction

    localparam logic [(Q+1)*TW_W-1:0] ROM = rom_init();

    function automatic logic [TW_W-1:0] rom_rd(input logic [MW-1:0] a);
        return ROM[int'(a)*TW_W +: TW_W];
    endfunction

    logic [1:0]    state;
    logic          rst_q, inv_q, en, accept, issue;
    logic [SW-1:0] s_q;
    logic [MW-1:0] cnt, sh, mi, ar, ai;
    logic          v1, l1, nr1, ni1, v2, l2, nr2, ni2;
    logic [MW-1:0] m1, ar1, ai1, m2;
    logic [TW_W-1:0] cr2, ci2;

    assign en = ~(out_valid & ~out_ready);
    assign busy = state != IDLE;
    assign accept = rst_q & start & ~busy;
    assign issue = accept | ((state == RUN) & en);
    assign sh = cnt << s_q;

    // index 0 always maps to m=0, so it is issued straight from the accept cycle
    always_comb begin
        mi = accept ? '0 : sh;
        ar = (mi > QM) ? '0 - mi : mi;
        ai = (mi > QM) ? mi - QM : QM - mi;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) rst_q <= 1'b0;
        else rst_q <= 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            s_q <= '0;
            inv_q <= 1'b0;
        end else if (accept) begin
            state <= RUN;
            cnt <= MW'(1);
            s_q <= (int'(stage) >= LOG2N) ? SW'(LOG2N - 1) : stage;
            inv_q <= inv;
        end else if (state == RUN && en) begin
            cnt <= cnt + 1'b1;
            if (&cnt) state <= DRAIN;
        end else if (state == DRAIN && out_valid && out_ready && out_last) begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {v1, l1, nr1, ni1, v2, l2, nr2, ni2} <= '0;
            {m1, ar1, ai1, m2, cr2, ci2} <= '0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_idx <= '0;
            twiddle_re <= '0;
            twiddle_im <= '0;
        end else if (en) begin
            v1 <= issue;
            l1 <= (state == RUN) & (&cnt);
            m1 <= mi;
            ar1 <= ar;
            ai1 <= ai;
            nr1 <= mi > QM;
            ni1 <= ~(accept ? inv : inv_q);
            v2 <= v1;
            l2 <= l1;
            m2 <= m1;
            nr2 <= nr1;
            ni2 <= ni1;
            cr2 <= rom_rd(ar1);
            ci2 <= rom_rd(ai1);
            out_valid <= v2;
            out_last <= l2;
            out_idx <= m2;
            twiddle_re <= nr2 ? -cr2 : cr2;
            twiddle_im <= ni2 ? -ci2 : ci2;
        end
    end
endmodule

// File: tb/tb_tw_gen.sv
// tb_tw_gen: directed/randomized bench for tw_gen against a trigonometric reference model.
module tb_tw_gen;
    logic clk = 1'b0, rst = 1'b1;
    logic start4 = 1'b0, start5 = 1'b0, inv4 = 1'b0, inv5 = 1'b0, out_ready = 1'b1;
    logic [1:0] stage4 = '0;
    logic [2:0] stage5 = '0;
    logic busy4, v4, last4, busy5, v5, last5;
    logic [2:0] idx4;
    logic [3:0] idx5;
    logic signed [11:0] re4, im4;
    logic signed [15:0] re5, im5;
    int sel = 0;
    int n_chk = 0, n_fail = 0;
    int b_o, v_o, l_o, i_o, re_o, im_o;

    tw_gen #(.LOG2N(4), .TW_W(12)) d4 (
        .clk(clk), .rst(rst), .start(start4), .stage(stage4), .inv(inv4),
        .busy(busy4), .out_valid(v4), .out_ready(out_ready), .out_last(last4),
        .out_idx(idx4), .twiddle_re(re4), .twiddle_im(im4)
    );

    tw_gen #(.LOG2N(5), .TW_W(16)) d5 (
        .clk(clk), .rst(rst), .start(start5), .stage(stage5), .inv(inv5),
        .busy(busy5), .out_valid(v5), .out_ready(out_ready), .out_last(last5),
        .out_idx(idx5), .twiddle_re(re5), .twiddle_im(im5)
    );

    always #5 clk = ~clk;

    always_comb begin
        b_o = (sel != 0) ? int'(busy5) : int'(busy4);
        v_o = (sel != 0) ? int'(v5) : int'(v4);
        l_o = (sel != 0) ? int'(last5) : int'(last4);
        i_o = (sel != 0) ? int'(idx5) : int'(idx4);
        re_o = (sel != 0) ? int'(re5) : int'(re4);
        im_o = (sel != 0) ? int'(im5) : int'(im4);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // W_N^m = cos(2*pi*m/N) - j*sin(2*pi*m/N), scaled and rounded
    function automatic void model(input int m, input bit iv, output int re, output int im);
        int lg = (sel != 0) ? 5 : 4;
        real a = real'((1 << (((sel != 0) ? 16 : 12) - 1)) - 1);
        real th = 2.0 * 3.14159265358979 * real'(m) / real'(1 << lg);
        re = rnd(a * $cos(th));
        im = -rnd(a * $sin(th));
        if (iv) im = -im;
    endfunction

    task automatic set_start(input bit b);
        if (sel != 0) start5 = b;
        else start4 = b;
    endtask

    task automatic kick(input int st, input bit iv);
        set_start(1'b1);
        stage4 = 2'(st);
        stage5 = 3'(st);
        inv4 = iv;
        inv5 = iv;
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0);
    endtask

    // entered at the negedge after the accepting edge
    task automatic run(input int st, input bit iv, input bit rnd_rdy, input bit mid,
                       input bit sol, input int stop_at, input string tag);
        int lg = (sel != 0) ? 5 : 4;
        int half = 1 << (lg - 1);
        int s = (st >= lg) ? lg - 1 : st;
        int k = 0, t = 0, first = -1, er = 0, ei = 0, p_idx = 0, p_re = 0, p_im = 0;
        bit stalled = 1'b0, rdy;
        chk({tag, "/busy_on_accept"}, b_o, 1);
        while (k < half && k != stop_at && t < 200) begin
            if (stalled) begin
                chk({tag, "/hold_valid"}, v_o, 1);
                chk({tag, "/hold_idx"}, i_o, p_idx);
                chk({tag, "/hold_re"}, re_o, p_re);
                chk({tag, "/hold_im"}, im_o, p_im);
            end
            if (v_o != 0 && first < 0) first = t;
            rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            set_start((mid && t == 5) || (sol && v_o != 0 && rdy && k == half - 1));
            if (v_o != 0 && rdy) begin
                model((k << s) % half, iv, er, ei);
                chk({tag, "/idx"}, i_o, (k << s) % half);
                chk({tag, "/re"}, re_o, er);
                chk({tag, "/im"}, im_o, ei);
                chk({tag, "/last"}, l_o, int'(k == half - 1));
                k++;
            end
            stalled = (v_o != 0) && !rdy;
            p_idx = i_o;
            p_re = re_o;
            p_im = im_o;
            @(posedge clk);
            t++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (k == stop_at) return;
        chk({tag, "/beats"}, k, half);
        chk({tag, "/latency"}, first, 2);
        if (!rnd_rdy) chk({tag, "/cycles"}, t, 2 + half);
        chk({tag, "/busy_end"}, b_o, 0);
        chk({tag, "/valid_end"}, v_o, 0);
    endtask

    initial begin
        int vcnt;
        #1 rst = 1'b0;
        #1;
        chk("rst/busy", b_o, 0);
        chk("rst/valid", v_o, 0);
        chk("rst/last", l_o, 0);
        chk("rst/idx", i_o, 0);
        chk("rst/re", re_o, 0);
        chk("rst/im", im_o, 0);
        chk("rst/valid5", int'(v5), 0);
        @(negedge clk);
        rst = 1'b1;
        set_start(1'b1);
        stage4 = 2'd0;
        inv4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("sync/busy_edge1", b_o, 0);
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0);
        run(0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "s0");
        kick(2, 1'b1);
        run(2, 1'b1, 1'b0, 1'b0, 1'b0, -1, "s2inv");
        kick(0, 1'b0);
        run(0, 1'b0, 1'b1, 1'b1, 1'b0, -1, "s0_rand");
        kick(0, 1'b0);
        run(0, 1'b0, 1'b0, 1'b0, 1'b1, -1, "s0_sol");
        kick(0, 1'b0);
        run(0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "s0_next");
        kick(0, 1'b0);
        run(0, 1'b0, 1'b0, 1'b0, 1'b0, 3, "rst_mid");
        rst = 1'b0;
        #1;
        chk("rst_mid/valid", v_o, 0);
        chk("rst_mid/busy", b_o, 0);
        chk("rst_mid/last", l_o, 0);
        chk("rst_mid/idx", i_o, 0);
        chk("rst_mid/re", re_o, 0);
        chk("rst_mid/im", im_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            vcnt += v_o;
        end
        chk("rst_mid/quiet_valid", vcnt, 0);
        chk("rst_mid/quiet_busy", b_o, 0);
        kick(1, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0, 1'b0, -1, "s1");
        sel = 1;
        #1;
        kick(7, 1'b0);
        run(7, 1'b0, 1'b0, 1'b0, 1'b0, -1, "n32_clamp");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
